seg_scroll_ctrl: RTL and testbench

Parametrised, time-multiplexed seven-segment display controller for NUM_DIGITS characters, each CHAR_W bits wide. It replaces the four per-display mux/decoder pairs, which were steered by a static select, with a single registered character buffer and a scan counter that drives one digit at a time. A prescaled rotation offset makes the characters scroll left or right automatically, and a blink mode is also provided. The block sits between the character source and the physical common-anode display pins.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_char_decode.sv | 20 ++
 rtl/seg_scroll_ctrl.sv | 149 ++++++++++++++
 tb/tb_seg_scroll_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the scrolling seven-segment controller: segment bus
// width, display modes and the character-to-segment pattern table.
package seg_pkg;

   localparam int SEG_W = 7;

   // Display mode field, all four encodings are meaningful
   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_ROT_L  = 2'b01,
      MODE_ROT_R  = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_e;

   // Segment patterns {a,b,c,d,e,f,g}, bit 6 = a, active-high
   localparam logic [SEG_W-1:0] SEG_CODE_0 = 7'b1111110;
   localparam logic [SEG_W-1:0] SEG_CODE_1 = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_CODE_2 = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_CODE_3 = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_CODE_4 = 7'b0110011;
   localparam logic [SEG_W-1:0] SEG_CODE_5 = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_CODE_6 = 7'b1011111;
   localparam logic [SEG_W-1:0] SEG_CODE_7 = 7'b1110000;

   // Packed lookup table, entry k holds the pattern for code k
   localparam logic [7:0][SEG_W-1:0] SEG_TABLE = {
      SEG_CODE_7, SEG_CODE_6, SEG_CODE_5, SEG_CODE_4,
      SEG_CODE_3, SEG_CODE_2, SEG_CODE_1, SEG_CODE_0
   };

endpackage

// File: rtl/seg_char_decode.sv
// Combinational character decoder: maps the low three bits of a character
// code onto a seven-segment pattern. Any wider code bits are ignored.
module seg_char_decode
   import seg_pkg::*;
#(
   parameter int CHAR_W = 3
) (
   input  logic [CHAR_W-1:0] code_i,
   output logic [SEG_W-1:0]  seg_o
);

   logic [2:0] code_idx;

   // Truncate (or zero-extend) the code to a table index and look it up
   always_comb begin
      code_idx = 3'(code_i);
      seg_o    = SEG_TABLE[code_idx];
   end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Time-multiplexed seven-segment controller. A registered character buffer
// is scanned one digit at a time; a prescaled rotation offset scrolls the
// characters left or right, or toggles a blink phase, once per step pulse.
module seg_scroll_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CHAR_W     = 3,
   parameter int SCAN_DIV   = 4,
   parameter int ROT_DIV    = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_DIGITS*CHAR_W-1:0]   chars_in,
   input  logic                           load,
   input  logic [1:0]                     mode,
   input  logic                           en,
   output logic [SEG_W-1:0]               seg_out,
   output logic [NUM_DIGITS-1:0]          an_out,
   output logic [$clog2(NUM_DIGITS)-1:0]  rot_pos
);

   localparam int POS_W  = $clog2(NUM_DIGITS);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int ROT_W  = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
   localparam int BUF_W  = NUM_DIGITS * CHAR_W;

   localparam logic [POS_W-1:0]  LAST_DIGIT = POS_W'(NUM_DIGITS - 1);
   localparam logic [POS_W:0]    NUM_DIG_W  = (POS_W + 1)'(NUM_DIGITS);
   localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [ROT_W-1:0]  ROT_LAST   = ROT_W'(ROT_DIV - 1);

   logic [BUF_W-1:0]      buf_q,       buf_d;
   logic [SCAN_W-1:0]     scan_cnt_q,  scan_cnt_d;
   logic [POS_W-1:0]      digit_idx_q, digit_idx_d;
   logic [ROT_W-1:0]      rot_cnt_q,   rot_cnt_d;
   logic [POS_W-1:0]      rot_pos_q,   rot_pos_d;
   logic                  blink_ph_q,  blink_ph_d;
   logic [SEG_W-1:0]      seg_q,       seg_d;
   logic [NUM_DIGITS-1:0] an_q,        an_d;

   mode_e             mode_cur;
   logic              step;
   logic              blank;
   logic [POS_W:0]    sel_sum;
   logic [POS_W-1:0]  sel_idx;
   logic [CHAR_W-1:0] sel_char;
   logic [SEG_W-1:0]  dec_seg;

   assign mode_cur = mode_e'(mode);
   assign step     = en && (rot_cnt_q == ROT_LAST);

   // Scan counter and active digit index, frozen while the display is disabled
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      scan_cnt_d  = scan_cnt_q;
      digit_idx_d = digit_idx_q;
      if (en) begin
         if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == LAST_DIGIT) ? '0 : digit_idx_q + POS_W'(1);
         end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
         end
      end
   end

   // Buffer capture, rotation prescaler and step action; load wins over a step
   always_comb begin
      buf_d      = buf_q;
      rot_cnt_d  = rot_cnt_q;
      rot_pos_d  = rot_pos_q;
      blink_ph_d = blink_ph_q;
      if (load) begin
         buf_d      = chars_in;
         rot_cnt_d  = '0;
         rot_pos_d  = '0;
         blink_ph_d = 1'b0;
      end else if (en) begin
         rot_cnt_d = step ? '0 : rot_cnt_q + ROT_W'(1);
         if (step) begin
            case (mode_cur)
               MODE_ROT_L: rot_pos_d = (rot_pos_q == LAST_DIGIT) ? '0 : rot_pos_q + POS_W'(1);
               MODE_ROT_R: rot_pos_d = (rot_pos_q == '0) ? LAST_DIGIT : rot_pos_q - POS_W'(1);
               MODE_BLINK: blink_ph_d = ~blink_ph_q;
               default:    ;
            endcase
         end
      end
   end

   // Physical digit d shows buffer character (d + rot_pos) mod NUM_DIGITS
   always_comb begin
      sel_sum  = {1'b0, digit_idx_q} + {1'b0, rot_pos_q};
      sel_idx  = POS_W'((sel_sum >= NUM_DIG_W) ? sel_sum - NUM_DIG_W : sel_sum);
      sel_char = buf_q[sel_idx*CHAR_W +: CHAR_W];
   end

   seg_char_decode #(
      .CHAR_W (CHAR_W)
   ) u_decode (
      .code_i (sel_char),
      .seg_o  (dec_seg)
   );

   // Next registered outputs: one-cold anode plus decoded pattern, or blank
   always_comb begin
      blank = !en || ((mode_cur == MODE_BLINK) && blink_ph_q);
      an_d  = '1;
      seg_d = '0;
      if (!blank) begin
         an_d  = ~(NUM_DIGITS'(1) << digit_idx_q);
         seg_d = dec_seg;
      end
   end

   // State and output registers; reset blanks the display at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the character buffer is a small register bank, not a RAM,
         // so it is cleared on reset like every other state element.
         buf_q       <= '0;
         scan_cnt_q  <= '0;
         digit_idx_q <= '0;
         rot_cnt_q   <= '0;
         rot_pos_q   <= '0;
         blink_ph_q  <= 1'b0;
         seg_q       <= '0;
         an_q        <= '1;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         buf_q       <= buf_d;
         scan_cnt_q  <= scan_cnt_d;
         digit_idx_q <= digit_idx_d;
         rot_cnt_q   <= rot_cnt_d;
         rot_pos_q   <= rot_pos_d;
         blink_ph_q  <= blink_ph_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign seg_out = seg_q;
   assign an_out  = an_q;
   assign rot_pos = rot_pos_q;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Self-checking bench for seg_scroll_ctrl: directed scenarios followed by
// randomized load/mode/enable/reset traffic, compared every cycle against a
// behavioural model built from plain modulo arithmetic on integer state.
module tb_seg_scroll_ctrl;

   localparam int N  = 4;
   localparam int CW = 3;
   localparam int SD = 2;
   localparam int RD = 8;

   logic            clk      = 1'b0;
   logic            rst_n    = 1'b0;
   logic [N*CW-1:0] chars_in = '0;
   logic            load     = 1'b0;
   logic [1:0]      mode     = 2'b00;
   logic            en       = 1'b0;
   logic [6:0]      seg_out;
   logic [N-1:0]    an_out;
   logic [1:0]      rot_pos;

   seg_scroll_ctrl #(
      .NUM_DIGITS (N),
      .CHAR_W     (CW),
      .SCAN_DIV   (SD),
      .ROT_DIV    (RD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .chars_in (chars_in),
      .load     (load),
      .mode     (mode),
      .en       (en),
      .seg_out  (seg_out),
      .an_out   (an_out),
      .rot_pos  (rot_pos)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference segment table, code k -> abcdefg
   logic [6:0] dec_tab [8] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};
   logic [6:0] static_exp [4] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001};
   logic [3:0] scan_seq [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                                4'b1011, 4'b1011, 4'b0111, 4'b0111};

   // Behavioural model: integer counters advanced with modulo arithmetic
   int         m_chars [N];
   int         m_scan  = 0;
   int         m_digit = 0;
   int         m_rcnt  = 0;
   int         m_pos   = 0;
   bit         m_blink = 1'b0;
   bit         m_step;
   logic [6:0] e_seg = '0;
   logic [N-1:0] e_an = '1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) m_chars[k] = 0;
         m_scan  = 0;
         m_digit = 0;
         m_rcnt  = 0;
         m_pos   = 0;
         m_blink = 1'b0;
         e_seg   = '0;
         e_an    = '1;
      end else begin
         e_an  = '1;
         e_seg = '0;
         if (en && !(mode == 2'b11 && m_blink)) begin
            e_an[m_digit] = 1'b0;
            e_seg = dec_tab[m_chars[(m_digit + m_pos) % N]];
         end
         m_step = en && (m_rcnt == RD - 1);
         if (load) begin
            for (int k = 0; k < N; k++) m_chars[k] = int'(chars_in[k*CW +: CW]);
            m_pos   = 0;
            m_rcnt  = 0;
            m_blink = 1'b0;
         end else if (en) begin
            m_rcnt = (m_rcnt + 1) % RD;
            if (m_step) begin
               case (mode)
                  2'b01:   m_pos = (m_pos + 1) % N;
                  2'b10:   m_pos = (m_pos + N - 1) % N;
                  2'b11:   m_blink = !m_blink;
                  default: ;
               endcase
            end
         end
         if (en) begin
            m_scan = m_scan + 1;
            if (m_scan == SD) begin
               m_scan  = 0;
               m_digit = (m_digit + 1) % N;
            end
         end
      end
   end

   // Advance one clock and compare all outputs against the model
   task automatic cyc();
      @(negedge clk);
      check("seg", seg_out, e_seg);
      check("an", an_out, e_an);
      check("rot_pos", rot_pos, m_pos);
   endtask

   task automatic load_chars(input int c0, input int c1, input int c2, input int c3,
                             input logic [1:0] m);
      chars_in = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
      mode     = m;
      load     = 1'b1;
      cyc();
      load     = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int guard;

      // Reset held for three clocks
      en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_an", an_out, 4'b1111);
      check("rst_seg", seg_out, 7'b0);
      check("rst_rot", rot_pos, 2'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         check("scan_seq", an_out, scan_seq[i]);
      end

      // Static display of 0,1,2,3
      load_chars(0, 1, 2, 3, 2'b00);
      for (int i = 0; i < 64; i++) begin
         cyc();
         for (int d = 0; d < N; d++)
            if (e_an[d] == 1'b0) check("static_digit", seg_out, static_exp[d]);
      end
      check("static_rot", rot_pos, 2'd0);

      // Rotate left
      load_chars(0, 1, 2, 3, 2'b01);
      repeat (7) cyc();
      check("rl_pre_step", rot_pos, 2'd0);
      cyc();
      check("rl_step", rot_pos, 2'd1);
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (e_an[0] == 1'b0) check("rl_digit0", seg_out, 7'b0110000);
         if (e_an[3] == 1'b0) check("rl_digit3", seg_out, 7'b1111110);
      end
      repeat (15) cyc();
      check("rl_pos3", rot_pos, 2'd3);
      cyc();
      check("rl_wrap", rot_pos, 2'd0);

      // Rotate right
      load_chars(6, 1, 0, 7, 2'b10);
      repeat (8) cyc();
      check("rr_step", rot_pos, 2'd3);
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (e_an[0] == 1'b0) check("rr_digit0", seg_out, 7'b1110000);
      end

      // Blink phases
      load_chars(0, 1, 2, 3, 2'b11);
      repeat (8) cyc();
      check("blink_vis_pre", an_out != 4'b1111, 1'b1);
      cyc();
      check("blink_off_an", an_out, 4'b1111);
      check("blink_off_seg", seg_out, 7'b0);
      repeat (7) cyc();
      check("blink_off_end", an_out, 4'b1111);
      cyc();
      check("blink_on", an_out != 4'b1111, 1'b1);

      // Load coincident with a step pulse (rot_cnt is 1 here, step on 7th edge)
      repeat (6) cyc();
      load = 1'b1;
      cyc();
      load = 1'b0;
      cyc();
      check("blink_load_prio", an_out != 4'b1111, 1'b1);
      load_chars(0, 1, 2, 3, 2'b01);
      repeat (7) cyc();
      load = 1'b1;
      cyc();
      load = 1'b0;
      check("rot_load_prio", rot_pos, 2'd0);

      // Enable drop while digit 2 is next
      load_chars(4, 5, 6, 7, 2'b00);
      guard = 0;
      while (m_digit != 2 && guard < 20) begin
         cyc();
         guard++;
      end
      check("wait_digit2", guard < 20, 1'b1);
      en = 1'b0;
      cyc();
      check("en_off_an", an_out, 4'b1111);
      check("en_off_seg", seg_out, 7'b0);
      repeat (4) cyc();
      en = 1'b1;
      cyc();
      check("en_resume", an_out, 4'b1011);

      // Asynchronous reset mid-rotation
      load_chars(1, 2, 3, 4, 2'b01);
      repeat (20) cyc();
      #2 rst_n = 1'b0;
      #1;
      check("arst_an", an_out, 4'b1111);
      check("arst_seg", seg_out, 7'b0);
      check("arst_rot", rot_pos, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom % 250 == 0) begin
            rst_n = 1'b0;
            #1;
            check("rnd_rst_an", an_out, 4'b1111);
            check("rnd_rst_rot", rot_pos, 2'd0);
            rst_n = 1'b1;
         end
         load = ($urandom % 16 == 0);
         if (load) chars_in = (N*CW)'($urandom);
         if ($urandom % 40 == 0) mode = 2'($urandom);
         en = ($urandom % 8 != 0);
         cyc();
      end
      load = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
